// File: rtl/race_tracker.sv
// Position and tail-capture tracker for the chicken-race board game.
// Accepts one flip result at a time, chains capture hops, and latches the winner.
module race_tracker #(
  parameter int NUM_PLAYERS = 4,
  parameter int TRACK_LEN   = 24,
  parameter int POS_W       = 5,
  parameter int PID_W       = 2,
  parameter int TAIL_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_game,
  input  logic                          flip_valid,
  input  logic                          flip_match,
  output logic                          flip_ready,
  output logic [PID_W-1:0]              turn,
  output logic [POS_W-1:0]              cur_pos,
  output logic [NUM_PLAYERS*POS_W-1:0]  pos_bus,
  output logic [NUM_PLAYERS*TAIL_W-1:0] tails_bus,
  output logic                          move_done,
  output logic                          win,
  output logic [PID_W-1:0]              winner
);

  localparam int                SPACING   = TRACK_LEN / NUM_PLAYERS;
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(TRACK_LEN - 1);
  localparam logic [PID_W-1:0]  LAST_PID  = PID_W'(NUM_PLAYERS - 1);
  localparam logic [TAIL_W-1:0] ALL_TAILS = TAIL_W'(NUM_PLAYERS);

  typedef enum logic [1:0] {IDLE, CHECK, WON} state_t;

  state_t              state_reg, state_next;
  logic [POS_W-1:0]    pos_reg   [NUM_PLAYERS];
  logic [POS_W-1:0]    pos_next  [NUM_PLAYERS];
  logic [TAIL_W-1:0]   tails_reg [NUM_PLAYERS];
  logic [TAIL_W-1:0]   tails_next[NUM_PLAYERS];
  logic [PID_W-1:0]    turn_reg, turn_next;
  logic [PID_W-1:0]    winner_reg, winner_next;
  logic [POS_W-1:0]    cur_pos_reg, cur_pos_next;
  logic                win_reg, win_next;
  logic                move_done_reg, move_done_next;
  logic                flip_ready_reg, flip_ready_next;
  logic [NUM_PLAYERS-1:0] hit_vec;
  logic                hit_any;
  logic [PID_W-1:0]    hit_idx;

  function automatic logic [POS_W-1:0] inc_pos(input logic [POS_W-1:0] p);
    return (p == LAST_POS) ? '0 : p + POS_W'(1);
  endfunction

  // At most one opponent can share the mover's tile, since tiles are never shared.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_hit
      assign hit_vec[gi] = (PID_W'(gi) != turn_reg) && (pos_reg[gi] == pos_reg[turn_reg]);
    end
  endgenerate

  assign hit_any = |hit_vec;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (hit_vec[i]) hit_idx = PID_W'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    tails_next     = tails_reg;
    turn_next      = turn_reg;
    win_next       = win_reg;
    winner_next    = winner_reg;
    move_done_next = 1'b0;
    if (new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_next[i]   = POS_W'(i * SPACING);
        tails_next[i] = TAIL_W'(1);
      end
      turn_next   = '0;
      win_next    = 1'b0;
      winner_next = '0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flip_valid) begin
            if (flip_match) begin
              pos_next[turn_reg] = inc_pos(pos_reg[turn_reg]);
              state_next         = CHECK;
            end else begin
              turn_next      = (turn_reg == LAST_PID) ? '0 : turn_reg + PID_W'(1);
              move_done_next = 1'b1;
            end
          end
        end
        CHECK: begin
          if (hit_any) begin
            tails_next[turn_reg] = tails_reg[turn_reg] + tails_reg[hit_idx];
            tails_next[hit_idx]  = '0;
            pos_next[turn_reg]   = inc_pos(pos_reg[turn_reg]);
          end else begin
            move_done_next = 1'b1;
            if (tails_reg[turn_reg] == ALL_TAILS) begin
              win_next    = 1'b1;
              winner_next = turn_reg;
              state_next  = WON;
            end else begin
              state_next = IDLE;
            end
          end
        end
        WON:     state_next = WON;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ready and cur_pos are registered from next-state values so they line up with state.
  assign flip_ready_next = (state_next == IDLE);
  assign cur_pos_next    = pos_next[turn_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_reg[i]   <= POS_W'(i * SPACING);
        tails_reg[i] <= TAIL_W'(1);
      end
      turn_reg       <= '0;
      winner_reg     <= '0;
      win_reg        <= 1'b0;
      move_done_reg  <= 1'b0;
      flip_ready_reg <= 1'b1;
      cur_pos_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      pos_reg        <= pos_next;
      tails_reg      <= tails_next;
      turn_reg       <= turn_next;
      winner_reg     <= winner_next;
      win_reg        <= win_next;
      move_done_reg  <= move_done_next;
      flip_ready_reg <= flip_ready_next;
      cur_pos_reg    <= cur_pos_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
      assign pos_bus[gi*POS_W +: POS_W]    = pos_reg[gi];
      assign tails_bus[gi*TAIL_W +: TAIL_W] = tails_reg[gi];
    end
  endgenerate

  assign flip_ready = flip_ready_reg;
  assign turn       = turn_reg;
  assign cur_pos    = cur_pos_reg;
  assign move_done  = move_done_reg;
  assign win        = win_reg;
  assign winner     = winner_reg;

endmodule

// File: tb/tb_race_tracker.sv
// Bench for race_tracker: directed game scenarios plus random flips against a
// board-level model that resolves each move as a whole (advance, capture loop, win test).
module tb_race_tracker;
  localparam int NP = 4;
  localparam int TL = 24;
  localparam int PW = 5;
  localparam int IW = 2;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            new_game;
  logic            flip_valid;
  logic            flip_match;
  logic            flip_ready;
  logic [IW-1:0]   turn;
  logic [PW-1:0]   cur_pos;
  logic [NP*PW-1:0] pos_bus;
  logic [NP*TW-1:0] tails_bus;
  logic            move_done;
  logic            win;
  logic [IW-1:0]   winner;

  int n_checks = 0;
  int n_errors = 0;

  int m_pos[NP];
  int m_tails[NP];
  int m_turn, m_win, m_winner;

  race_tracker #(.NUM_PLAYERS(NP), .TRACK_LEN(TL), .POS_W(PW), .PID_W(IW), .TAIL_W(TW)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .flip_valid(flip_valid),
    .flip_match(flip_match), .flip_ready(flip_ready), .turn(turn), .cur_pos(cur_pos),
    .pos_bus(pos_bus), .tails_bus(tails_bus), .move_done(move_done), .win(win),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < NP; i++) begin
      m_pos[i]   = i * (TL / NP);
      m_tails[i] = 1;
    end
    m_turn = 0;
    m_win = 0;
    m_winner = 0;
  endfunction

  // Returns the number of capture hops; -1 for a miss.
  function automatic int model_flip(input bit m);
    int hops;
    int k;
    if (!m) begin
      m_turn = (m_turn + 1) % NP;
      return -1;
    end
    m_pos[m_turn] = (m_pos[m_turn] + 1) % TL;
    hops = 0;
    forever begin
      k = -1;
      for (int i = 0; i < NP; i++)
        if (i != m_turn && m_pos[i] == m_pos[m_turn]) k = i;
      if (k < 0) break;
      m_tails[m_turn] += m_tails[k];
      m_tails[k] = 0;
      m_pos[m_turn] = (m_pos[m_turn] + 1) % TL;
      hops++;
    end
    if (m_tails[m_turn] == NP) begin
      m_win = 1;
      m_winner = m_turn;
    end
    return hops;
  endfunction

  task automatic compare_board(input string where);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s pos%0d", where, i), 32'(pos_bus[i*PW +: PW]), m_pos[i]);
      check($sformatf("%s tails%0d", where, i), 32'(tails_bus[i*TW +: TW]), m_tails[i]);
    end
    check($sformatf("%s turn", where), 32'(turn), m_turn);
    check($sformatf("%s cur_pos", where), 32'(cur_pos), m_pos[m_turn]);
    check($sformatf("%s win", where), 32'(win), m_win);
    check($sformatf("%s winner", where), 32'(winner), m_winner);
  endtask

  // Called at a negedge with the DUT idle; returns the number of ready-low cycles seen.
  task automatic flip(input bit m, output int low);
    int hops, exp_low, cyc, p;
    p = m_turn;
    check("ready_before", 32'(flip_ready), 1);
    flip_valid = 1'b1;
    flip_match = m;
    @(negedge clk);
    hops = model_flip(m);
    exp_low = m ? hops + 1 : 0;
    low = 0;
    cyc = 0;
    while (move_done !== 1'b1 && cyc < 40) begin
      if (flip_ready === 1'b0) low++;
      flip_valid = 1'($urandom_range(0, 1));
      flip_match = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    flip_valid = 1'b0;
    check("move_done_seen", 32'(move_done), 1);
    check("ready_low_cycles", low, exp_low);
    check("ready_after", 32'(flip_ready), m_win ? 0 : 1);
    compare_board("flip");
    @(negedge clk);
    check("move_done_single", 32'(move_done), 0);
    $display("flip player=%0d match=%0d hops=%0d low=%0d win=%0d", p, m, hops, low, m_win);
  endtask

  task automatic hold_won(input int n);
    for (int i = 0; i < n; i++) begin
      flip_valid = 1'b1;
      flip_match = 1'($urandom_range(0, 1));
      @(negedge clk);
      compare_board("won_hold");
      check("won_ready", 32'(flip_ready), 0);
      check("won_move_done", 32'(move_done), 0);
    end
    flip_valid = 1'b0;
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_init();
    compare_board("new_game");
    check("new_game_ready", 32'(flip_ready), 1);
    check("new_game_move_done", 32'(move_done), 0);
    $display("new_game");
  endtask

  initial begin
    int low;
    rst = 1'b1;
    new_game = 1'b0;
    flip_valid = 1'b0;
    flip_match = 1'b0;
    model_init();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare_board("reset");
    check("reset_ready", 32'(flip_ready), 1);
    check("reset_move_done", 32'(move_done), 0);

    // Four misses rotate the turn back to player 0.
    for (int i = 0; i < 4; i++) flip(1'b0, low);
    check("misses_turn", 32'(turn), 0);

    // Player 0 walks onto player 1 at tile 6.
    for (int i = 0; i < 5; i++) flip(1'b1, low);
    check("p0_pos5", 32'(pos_bus[0 +: PW]), 5);
    flip(1'b1, low);
    check("cap_low", low, 2);
    check("cap_pos0", 32'(pos_bus[0 +: PW]), 7);
    check("cap_tails0", 32'(tails_bus[0 +: TW]), 2);
    check("cap_tails1", 32'(tails_bus[TW +: TW]), 0);
    start_new_game();

    // Wrap and chained capture by player 3, then the winning capture.
    for (int i = 0; i < 5; i++) flip(1'b1, low);
    for (int i = 0; i < 3; i++) flip(1'b0, low);
    for (int i = 0; i < 11; i++) flip(1'b1, low);
    check("chain_low", low, 3);
    check("chain_pos3", 32'(pos_bus[3*PW +: PW]), 7);
    check("chain_tails3", 32'(tails_bus[3*TW +: TW]), 3);
    for (int i = 0; i < 5; i++) flip(1'b1, low);
    check("win_flag", 32'(win), 1);
    check("win_winner", 32'(winner), 3);
    check("win_pos3", 32'(pos_bus[3*PW +: PW]), 13);
    hold_won(4);
    start_new_game();

    // Asynchronous reset in the middle of a capture.
    for (int i = 0; i < 5; i++) flip(1'b1, low);
    flip_valid = 1'b1;
    flip_match = 1'b1;
    @(negedge clk);
    flip_valid = 1'b0;
    check("mid_check_ready", 32'(flip_ready), 0);
    rst = 1'b1;
    #1;
    model_init();
    compare_board("rst_mid_check");
    check("rst_mid_move_done", 32'(move_done), 0);
    check("rst_mid_ready", 32'(flip_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare_board("after_rst");
    $display("rst during capture");

    // new_game overrides an in-progress capture.
    for (int i = 0; i < 5; i++) flip(1'b1, low);
    flip_valid = 1'b1;
    flip_match = 1'b1;
    @(negedge clk);
    flip_valid = 1'b0;
    start_new_game();

    // Random play against the model.
    for (int it = 0; it < 300; it++) begin
      if (m_win != 0) begin
        hold_won(3);
        start_new_game();
      end else if ($urandom_range(0, 49) == 0) begin
        start_new_game();
      end else begin
        flip($urandom_range(0, 99) < 75, low);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/race_tracker.md
# race_tracker

Parametrised position and tail-capture tracker for the chicken-race board game. It is the next generation of the per-player win checker: N players on a circular track, an internal turn pointer, multi-hop capture of chickens landed on, tail bookkeeping, and a latched winner. It sits between the tile-flip/compare logic, which supplies one match/miss result per flip, and the display/position logic, which reads positions, tails, turn and winner.

## Interface
- NUM_PLAYERS, 4, number of players, 2..8
- TRACK_LEN, 24, tiles on the circular track; must be a multiple of NUM_PLAYERS and ≤ 2^POS_W
- POS_W, 5, position width
- PID_W, 2, player-index width, ≥ clog2(NUM_PLAYERS)
- TAIL_W, 3, tail-count width, ≥ clog2(NUM_PLAYERS+1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- new_game  in  1  synchronous restart to the initial board
- flip_valid  in  1  flip result offered
- flip_match  in  1  1 = tile matched, 0 = miss; qualified by flip_valid
- flip_ready  out  1  flip result accepted when flip_valid & flip_ready
- turn  out  PID_W  player whose flip is expected
- cur_pos  out  POS_W  position of player `turn`
- pos_bus  out  NUM_PLAYERS*POS_W  all positions; player i at bits [i*POS_W +: POS_W]
- tails_bus  out  NUM_PLAYERS*TAIL_W  all tail counts, packed the same way
- move_done  out  1  one-cycle pulse when a flip's effects are complete
- win  out  1  a player holds all tails
- winner  out  PID_W  winning player; valid while win=1

## Operation
- Initial board, applied on rst or new_game: pos[i] = i*(TRACK_LEN/NUM_PLAYERS); tails[i] = 1; turn = 0; state IDLE; win = 0; winner = 0; move_done = 0.
- Invariant: no two players ever share a tile.
- States are IDLE, CHECK and WON.
- IDLE: flip_ready = 1.
  - On an accepted miss: turn advances to turn+1, wrapping from NUM_PLAYERS-1 to 0. State stays IDLE.
  - On an accepted match: pos[turn] advances by 1, wrapping TRACK_LEN-1 to 0. Next state is CHECK. The turn is kept.
- CHECK: flip_ready = 0. pos[turn] is compared against every other player.
  - Hit on player k: tails[turn] += tails[k]; tails[k] = 0; pos[turn] advances by 1 (the hop, with wrap). State stays CHECK, so hops chain. A chain runs at most NUM_PLAYERS-1 hops.
  - No hit, and tails[turn] == NUM_PLAYERS: win = 1, winner = turn, next state WON.
  - No hit otherwise: next state IDLE.
- WON: flip_ready = 0. Flips are ignored and all outputs hold. Leaves only on new_game or rst.
- A captured player keeps its position and still takes turns with 0 tails. The tail sum is always NUM_PLAYERS, so there is no overflow.
- new_game takes priority over any flip or CHECK activity in the same cycle. rst overrides everything, asynchronously.

## Timing
- All outputs are registered. Reset values are the initial-board values above; flip_ready = 1 once out of reset.
- Miss: accept at edge E. At E+1, turn is updated and move_done = 1 for that single cycle.
- Match without capture: accept at E; state is CHECK during E..E+1; IDLE at E+2. move_done pulses in the cycle starting at E+2, at which point pos, tails and win are all final.
- Each capture hop adds one CHECK cycle. flip_ready is low for 1+h cycles, where h is the number of hops.
- A winning move pulses move_done in the first WON cycle, which is also the cycle where win rises.
- flip_valid while flip_ready = 0 is not accepted and has no effect; the source holds it.
- An rst that arrives mid-CHECK abandons the move: no partial capture persists, and move_done is not pulsed.

## Test plan
NUM_PLAYERS=4, TRACK_LEN=24; initial positions 0/6/12/18.
- Reset → pos 0/6/12/18, tails 1/1/1/1, turn 0, flip_ready 1, win 0, move_done 0.
- Four misses → turn 1, 2, 3, 0; one move_done per miss; positions unchanged.
- Player 0: 5 matches → pos0 = 5, turn stays 0. Sixth match lands on 6 → tails0 = 2, tails1 = 0, pos0 = 7; flip_ready low for exactly 2 cycles.
- From reset, wrap and chain:
  - Player 0: 5 matches then a miss (pos0 = 5, turn 1). Players 1 and 2 miss.
  - Player 3: 11 matches → path 18→23→0→5, capture p0, hop to 6, capture p1, hop to 7.
  - Expected: tails3 = 3, tails0 = tails1 = 0, pos3 = 7; flip_ready low 3 cycles on the last match.
- Continue player 3: 5 matches reach 12 → capture p2, pos3 = 13, tails3 = 4, win = 1, winner = 3, flip_ready = 0. A further flip_valid changes nothing.
- rst asserted during CHECK → initial board immediately. Separately, new_game in WON → initial board next cycle with flip_ready = 1.
